// File: rtl/ram8_pkg.sv
// ram8_pkg: constants and helpers shared by the Hack memory hierarchy slice.
//   HACK_WORD_W      - data word width (16 for Hack)
//   RAM8_ADDR_W      - address width of one ram8 stage
//   RAM8_DEPTH       - words per ram8 stage
//   HACK_WORD_RESET  - value every storage word takes on reset
//   ram8_write_en()  - one-hot write-enable decode of (load, address)
package ram8_pkg;

  localparam int HACK_WORD_W = 16;
  localparam int RAM8_ADDR_W = 3;
  localparam int RAM8_DEPTH  = 1 << RAM8_ADDR_W;

  localparam logic [HACK_WORD_W-1:0] HACK_WORD_RESET = 16'h0000;

  // en[i] = load & (address == i); at most one bit can ever be set.
  function automatic logic [RAM8_DEPTH-1:0] ram8_write_en(
    input logic                   load,
    input logic [RAM8_ADDR_W-1:0] address
  );
    logic [RAM8_DEPTH-1:0] en;
    en = '0;
    for (int i = 0; i < RAM8_DEPTH; i++) begin
      en[i] = load & (address == RAM8_ADDR_W'(i));
    end
    return en;
  endfunction

endpackage

// File: rtl/ram8_mux8way16.sv
// mux8way16: 8-way WIDTH-bit combinational multiplexer.
// Ports:
//   a..h - data inputs, selected by sel = 0..7 respectively
//   sel  - 3-bit select
//   out  - selected input
module mux8way16
  import ram8_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = a;
    case (sel)
      3'd0:    out = a;
      3'd1:    out = b;
      3'd2:    out = c;
      3'd3:    out = d;
      3'd4:    out = e;
      3'd5:    out = f;
      3'd6:    out = g;
      3'd7:    out = h;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/ram8_register16.sv
// register16: loadable WIDTH-bit register with asynchronous active-low clear.
// Ports:
//   clk   - rising-edge clock
//   rst_n - async active-low reset, clears to HACK_WORD_RESET
//   in    - data to load
//   load  - when high at a rising edge, out takes in on that edge
//   out   - registered value (out(t+1) = in(t) when load(t))
module register16
  import ram8_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= WIDTH'(HACK_WORD_RESET);
    end else if (load) begin
      r_q <= in;
    end
  end

  assign out = r_q;

endmodule

// File: rtl/ram8.sv
// ram8: 8-word x WIDTH-bit RAM, smallest memory stage of the Hack hierarchy.
// Ports:
//   clk     - rising-edge clock; writes commit on this edge
//   rst_n   - async active-low reset; clears all words immediately
//   in      - write data
//   load    - write enable, sampled on the rising edge
//   address - word select shared by read and write
//   out     - combinational read data, mem[address]
// Interface contract: no handshake. Reads are combinational with zero
// latency; a write presented with load=1 commits at the next rising edge.
// Read-during-write to the same word shows the old word until the edge.
// The block has no state beyond its eight words.
module ram8
  import ram8_pkg::*;
#(
  parameter int WIDTH      = HACK_WORD_W,
  parameter int DEPTH_LOG2 = RAM8_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in,
  input  logic                  load,
  input  logic [DEPTH_LOG2-1:0] address,
  output logic [WIDTH-1:0]      out
);

  logic [RAM8_DEPTH-1:0] w_en;
  logic [WIDTH-1:0]      w_word [RAM8_DEPTH];

  // One-hot decode: only the addressed word sees load.
  assign w_en = ram8_write_en(load, RAM8_ADDR_W'(address));

  for (genvar i = 0; i < RAM8_DEPTH; i++) begin : g_word
    register16 #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .load  (w_en[i]),
      .out   (w_word[i])
    );
  end

  // Read straight from the register outputs: no bypass from in, so a
  // same-address write becomes visible only after the edge.
  mux8way16 #(.WIDTH(WIDTH)) u_rd_mux (
    .a   (w_word[0]),
    .b   (w_word[1]),
    .c   (w_word[2]),
    .d   (w_word[3]),
    .e   (w_word[4]),
    .f   (w_word[5]),
    .g   (w_word[6]),
    .h   (w_word[7]),
    .sel (3'(address)),
    .out (out)
  );

endmodule

// File: tb/tb_ram8.sv
module tb_ram8;
  import ram8_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_d;
  logic         load;
  logic [2:0]   address;
  logic [W-1:0] out_d;

  always #5 clk = ~clk;

  ram8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in_d),
    .load    (load),
    .address (address),
    .out     (out_d)
  );

  // ---------------- reference model ----------------
  // Plain array of words: a write lands at the edge if reset is released.
  logic [W-1:0] model_mem [8];

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  event         check_ev;

  // Driver side: push the expected read value, then present it to the monitor.
  task automatic expect_out(input string nm, input logic [W-1:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
    ->check_ev;
    #2;
  endtask

  // Monitor: pops one expectation per presented read and compares.
  initial begin : monitor
    logic [W-1:0] e;
    string        nm;
    forever begin
      @(check_ev);
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL monitor_underflow: read presented with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (out_d !== e) begin
          n_fail++;
          $display("FAIL %s: addr=%0d out=%h expected=%h at %0t", nm, address, out_d, e, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    @(negedge clk);
    address = a;
    in_d    = d;
    load    = 1'b1;
    @(posedge clk);
    if (rst_n) model_mem[a] = d;
    #1;
    load = 1'b0;
  endtask

  task automatic sweep(input string nm);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      expect_out(nm, model_mem[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    logic [W-1:0] snap [8];

    rst_n   = 1'b0;
    load    = 1'b0;
    address = 3'd0;
    in_d    = '0;
    model_clear();
    #12;
    expect_out("reset_initial", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. async reset clears every word without a clock edge
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hFFFF);
    sweep("pre_reset_ffff");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      expect_out("reset_clear", 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // 2. fill and combinational readback
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + W'(i));
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      expect_out("fill_readback", 16'h1000 + W'(i));
    end

    // 3. load=0 holds across edges
    wr(3'd3, 16'hBEEF);
    @(negedge clk);
    address = 3'd3;
    in_d    = 16'h1234;
    load    = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      expect_out("load0_hold", 16'hBEEF);
    end

    // 4. read-during-write: old word before the edge, new word after
    wr(3'd5, 16'h0055);
    @(negedge clk);
    address = 3'd5;
    in_d    = 16'hAAAA;
    load    = 1'b1;
    #1;
    expect_out("rdw_old", 16'h0055);
    @(posedge clk);
    model_mem[5] = 16'hAAAA;
    #1;
    expect_out("rdw_new", 16'hAAAA);
    load = 1'b0;

    // 5. isolation: writing word 7 leaves words 0..6 alone
    for (int i = 0; i < 8; i++) snap[i] = model_mem[i];
    @(negedge clk);
    address = 3'd0;
    expect_out("iso_addr0_before", snap[0]);
    wr(3'd7, 16'h7FFF);
    for (int i = 0; i < 7; i++) begin
      address = 3'(i);
      expect_out("iso_hold", snap[i]);
    end
    address = 3'd7;
    expect_out("iso_word7", 16'h7FFF);

    // 6. reset asserted in the same cycle as a write: write is lost
    @(negedge clk);
    address = 3'd2;
    in_d    = 16'hC0DE;
    load    = 1'b1;
    rst_n   = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    expect_out("rst_during_write", 16'h0000);
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    #1;
    expect_out("rst_write_lost", 16'h0000);
    sweep("post_reset_sweep");

    // first edge after release is a normal write
    wr(3'd2, 16'h2222);
    address = 3'd2;
    expect_out("first_edge_after_release", 16'h2222);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      address = 3'($urandom_range(0, 7));
      in_d    = W'($urandom);
      load    = ($urandom_range(0, 3) != 0);
      expect_out("rand_pre_edge", model_mem[address]);
      if ($urandom_range(0, 1) == 1 && !load) begin
        address = 3'($urandom_range(0, 7));
        expect_out("rand_addr_change", model_mem[address]);
      end
      @(posedge clk);
      if (load) model_mem[address] = in_d;
      #1;
      expect_out("rand_post_edge", model_mem[address]);
    end
    @(negedge clk);
    load = 1'b0;
    sweep("final_sweep");

    // drain the scoreboard with a bounded wait
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
